// File: rtl/mem_rd_ctrl.sv
// Purpose: ME-stage load sequencer; fetches one or two 16-byte cache lines and extracts a little-endian operand.
// Latency: accept -> RD_VALID in 2 cycles (single line, immediate ACK) or 3 cycles (line-crossing split).
// Backpressure: holds RD_VALID/RD_DATA in DONE until EX_READY; ME_STALL high whenever busy. Option macro: MEM_RD_SPLIT_EN.
module mem_rd_ctrl (
    input  logic         CLK,
    input  logic         RST,
    input  logic         V,
    input  logic         MEM_RD_ME,
    input  logic [31:0]  MEM_RD_ADDR,
    input  logic [1:0]   MEM_SIZE,
    input  logic         EXC_IN,
    input  logic         EX_READY,
    output logic         DC_REQ,
    output logic [31:0]  DC_ADDR,
    input  logic         DC_ACK,
    input  logic [127:0] DC_DATA,
    output logic [63:0]  RD_DATA,
    output logic         RD_VALID,
    output logic         ME_STALL,
    output logic         MISALIGN_EXC
);

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    addr_q;
    logic [1:0]     size_q;
    logic           cross_q;
    logic [127:0]   line0;
    logic [127:0]   line1;

    logic           accept;
    logic [4:0]     nbytes_in;
    logic           cross_in;
    logic [31:0]    line_addr;
    logic [31:0]    next_line_addr;
    logic [6:0]     shamt;
    logic [63:0]    byte_mask;
    logic [63:0]    extract;

    assign accept         = (state == IDLE) && V && MEM_RD_ME && !EXC_IN;
    assign line_addr      = {addr_q[31:4], 4'h0};
    // Natural 32-bit wrap takes the last line back to address zero.
    assign next_line_addr = line_addr + 32'd16;
    assign ME_STALL       = (state != IDLE);

    // Operand byte count and line-crossing test for the incoming micro-op.
    always_comb begin
        nbytes_in = 5'd1;
        case (MEM_SIZE)
            2'b00:   nbytes_in = 5'd1;
            2'b01:   nbytes_in = 5'd2;
            2'b10:   nbytes_in = 5'd4;
            default: nbytes_in = 5'd8;
        endcase
        cross_in = (({1'b0, MEM_RD_ADDR[3:0]} + nbytes_in) > 5'd16);
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request attributes captured at accept; line buffers captured on ACK in the matching state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            cross_q <= 1'b0;
            line0   <= 128'd0;
            line1   <= 128'd0;
        end else begin
            if (accept) begin
                addr_q  <= MEM_RD_ADDR;
                size_q  <= MEM_SIZE;
                cross_q <= cross_in;
            end
            if ((state == REQ1) && DC_ACK) begin
                line0 <= DC_DATA;
            end
            if ((state == REQ2) && DC_ACK) begin
                line1 <= DC_DATA;
            end
        end
    end

    // Next-state and cache-request outputs.
    always_comb begin
        state_nxt = state;
        DC_REQ    = 1'b0;
        DC_ADDR   = 32'd0;
        RD_VALID  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ1;
                end
            end
            REQ1: begin
                DC_REQ  = 1'b1;
                DC_ADDR = line_addr;
                if (DC_ACK) begin
`ifdef MEM_RD_SPLIT_EN
                    state_nxt = cross_q ? REQ2 : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            REQ2: begin
                DC_REQ  = 1'b1;
                DC_ADDR = next_line_addr;
                if (DC_ACK) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                RD_VALID = 1'b1;
                if (EX_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte extraction from {line1,line0} starting at the line offset, zeroed above the operand size.
    always_comb begin
        byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_q)
            2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
            2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        shamt   = {addr_q[3:0], 3'b000};
        extract = 64'({line1, line0} >> shamt) & byte_mask;
    end

    // Result and misalignment reporting; both only visible in DONE.
`ifdef MEM_RD_SPLIT_EN
    assign RD_DATA      = (state == DONE) ? extract : 64'd0;
    assign MISALIGN_EXC = 1'b0;
`else
    // Without split support a crossing read is refused after the first line fetch.
    assign RD_DATA      = ((state == DONE) && !cross_q) ? extract : 64'd0;
    assign MISALIGN_EXC = (state == DONE) && cross_q;
`endif

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Purpose: directed self-checking bench for mem_rd_ctrl (aligned, split, wrap, backpressure, suppression, async reset).
// Latency: inputs driven and outputs sampled on the falling edge, away from the active rising edge.
// Backpressure: EX_READY held low in DONE to check result hold; expectations follow MEM_RD_SPLIT_EN.
module tb_mem_rd_ctrl;

    logic         clk;
    logic         rst;
    logic         v;
    logic         mem_rd_me;
    logic [31:0]  mem_rd_addr;
    logic [1:0]   mem_size;
    logic         exc_in;
    logic         ex_ready;
    logic         dc_req;
    logic [31:0]  dc_addr;
    logic         dc_ack;
    logic [127:0] dc_data;
    logic [63:0]  rd_data;
    logic         rd_valid;
    logic         me_stall;
    logic         misalign_exc;

    int checks;
    int errors;

    logic [63:0] exp_split_data;
    logic [63:0] exp_wrap_data;
    logic        exp_mis;

    mem_rd_ctrl dut (
        .CLK          (clk),
        .RST          (rst),
        .V            (v),
        .MEM_RD_ME    (mem_rd_me),
        .MEM_RD_ADDR  (mem_rd_addr),
        .MEM_SIZE     (mem_size),
        .EXC_IN       (exc_in),
        .EX_READY     (ex_ready),
        .DC_REQ       (dc_req),
        .DC_ADDR      (dc_addr),
        .DC_ACK       (dc_ack),
        .DC_DATA      (dc_data),
        .RD_DATA      (rd_data),
        .RD_VALID     (rd_valid),
        .ME_STALL     (me_stall),
        .MISALIGN_EXC (misalign_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        l = 128'd0;
        for (int k = 0; k < 16; k++) begin
            l[8*k +: 8] = base + 8'(k);
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        v           = 1'b0;
        mem_rd_me   = 1'b0;
        mem_rd_addr = 32'd0;
        mem_size    = 2'd0;
        exc_in      = 1'b0;
        ex_ready    = 1'b1;
        dc_ack      = 1'b0;
        dc_data     = 128'd0;

`ifdef MEM_RD_SPLIT_EN
        exp_split_data = 64'hB3B2_B1B0_AFAE_ADAC;
        exp_wrap_data  = 64'h0000_0000_0000_B0AF;
        exp_mis        = 1'b0;
`else
        exp_split_data = 64'd0;
        exp_wrap_data  = 64'd0;
        exp_mis        = 1'b1;
`endif

        // Reset state
        #1;
        chk("rst_dc_req",   64'(dc_req),       64'd0);
        chk("rst_dc_addr",  64'(dc_addr),      64'd0);
        chk("rst_rd_valid", 64'(rd_valid),     64'd0);
        chk("rst_me_stall", 64'(me_stall),     64'd0);
        chk("rst_misalign", 64'(misalign_exc), 64'd0);
        chk("rst_rd_data",  rd_data,           64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Aligned dword at 0x1004 with immediate ACK
        dc_data     = mk_line(8'h00);
        v           = 1'b1;
        mem_rd_me   = 1'b1;
        mem_rd_addr = 32'h0000_1004;
        mem_size    = 2'b10;
        dc_ack      = 1'b1;
        ex_ready    = 1'b1;
        @(negedge clk);
        chk("al_req1_dc_req",  64'(dc_req),   64'd1);
        chk("al_req1_dc_addr", 64'(dc_addr),  64'h1000);
        chk("al_req1_stall",   64'(me_stall), 64'd1);
        chk("al_req1_valid",   64'(rd_valid), 64'd0);
        v           = 1'b0;
        mem_rd_addr = 32'hDEAD_BEEF;
        mem_size    = 2'b00;
        @(negedge clk);
        chk("al_done_valid", 64'(rd_valid),     64'd1);
        chk("al_done_data",  rd_data,           64'h0000_0000_0706_0504);
        chk("al_done_req",   64'(dc_req),       64'd0);
        chk("al_done_mis",   64'(misalign_exc), 64'd0);
        // New request offered on the same edge DONE retires: must not be taken
        v           = 1'b1;
        mem_rd_addr = 32'h0000_0040;
        @(negedge clk);
        chk("al_idle_stall", 64'(me_stall), 64'd0);
        chk("al_idle_req",   64'(dc_req),   64'd0);
        chk("al_idle_valid", 64'(rd_valid), 64'd0);

        // Suppression: flagged exception, then no memory read
        exc_in      = 1'b1;
        mem_rd_addr = 32'h0000_3000;
        @(negedge clk);
        chk("sup_exc_req",   64'(dc_req),   64'd0);
        chk("sup_exc_stall", 64'(me_stall), 64'd0);
        exc_in    = 1'b0;
        mem_rd_me = 1'b0;
        @(negedge clk);
        chk("sup_nord_stall", 64'(me_stall), 64'd0);
        v = 1'b0;

        // Split qword at 0x200C, delayed first ACK, backpressure in DONE
        dc_data     = mk_line(8'hA0);
        dc_ack      = 1'b0;
        ex_ready    = 1'b0;
        v           = 1'b1;
        mem_rd_me   = 1'b1;
        mem_rd_addr = 32'h0000_200C;
        mem_size    = 2'b11;
        @(negedge clk);
        chk("sp_req1_dc_req",  64'(dc_req),  64'd1);
        chk("sp_req1_dc_addr", 64'(dc_addr), 64'h2000);
        v           = 1'b0;
        exc_in      = 1'b1;
        mem_rd_addr = 32'h0000_5555;
        @(negedge clk);
        chk("sp_hold_dc_req",  64'(dc_req),  64'd1);
        chk("sp_hold_dc_addr", 64'(dc_addr), 64'h2000);
        exc_in = 1'b0;
        dc_ack = 1'b1;
        @(negedge clk);
`ifdef MEM_RD_SPLIT_EN
        chk("sp_req2_dc_req",  64'(dc_req),  64'd1);
        chk("sp_req2_dc_addr", 64'(dc_addr), 64'h2010);
        dc_data = mk_line(8'hB0);
        @(negedge clk);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("sp_bp_valid", 64'(rd_valid),     64'd1);
            chk("sp_bp_data",  rd_data,           exp_split_data);
            chk("sp_bp_stall", 64'(me_stall),     64'd1);
            chk("sp_bp_mis",   64'(misalign_exc), 64'(exp_mis));
            chk("sp_bp_req",   64'(dc_req),       64'd0);
            @(negedge clk);
        end
        chk("sp_done_valid", 64'(rd_valid), 64'd1);
        ex_ready = 1'b1;
        @(negedge clk);
        chk("sp_idle_valid", 64'(rd_valid),     64'd0);
        chk("sp_idle_stall", 64'(me_stall),     64'd0);
        chk("sp_idle_mis",   64'(misalign_exc), 64'd0);

        // Word at 0xFFFFFFFF: second line wraps to address zero
        dc_data     = mk_line(8'hA0);
        dc_ack      = 1'b1;
        v           = 1'b1;
        mem_rd_addr = 32'hFFFF_FFFF;
        mem_size    = 2'b01;
        @(negedge clk);
        chk("wr_req1_dc_addr", 64'(dc_addr), 64'hFFFF_FFF0);
        v = 1'b0;
        @(negedge clk);
`ifdef MEM_RD_SPLIT_EN
        chk("wr_req2_dc_req",  64'(dc_req),  64'd1);
        chk("wr_req2_dc_addr", 64'(dc_addr), 64'h0000_0000);
        dc_data = mk_line(8'hB0);
        @(negedge clk);
`endif
        chk("wr_done_valid", 64'(rd_valid),     64'd1);
        chk("wr_done_data",  rd_data,           exp_wrap_data);
        chk("wr_done_mis",   64'(misalign_exc), 64'(exp_mis));
        @(negedge clk);
        chk("wr_idle_stall", 64'(me_stall), 64'd0);

        // Asynchronous reset while waiting for a line ACK
        dc_data     = mk_line(8'hA0);
        dc_ack      = 1'b0;
        v           = 1'b1;
        mem_rd_addr = 32'h0000_200C;
        mem_size    = 2'b11;
        @(negedge clk);
        v = 1'b0;
`ifdef MEM_RD_SPLIT_EN
        dc_ack = 1'b1;
        @(negedge clk);
        dc_ack = 1'b0;
`endif
        @(negedge clk);
        chk("ar_wait_dc_req", 64'(dc_req), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_async_dc_req",  64'(dc_req),   64'd0);
        chk("ar_async_stall",   64'(me_stall), 64'd0);
        chk("ar_async_dc_addr", 64'(dc_addr),  64'd0);
        @(negedge clk);
        rst    = 1'b1;
        dc_ack = 1'b1;
        @(negedge clk);
        chk("ar_post_valid1", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("ar_post_valid2", 64'(rd_valid), 64'd0);
        chk("ar_post_stall",  64'(me_stall), 64'd0);

        // Byte read at address zero after release
        v           = 1'b1;
        mem_rd_addr = 32'h0000_0000;
        mem_size    = 2'b00;
        @(negedge clk);
        chk("by_req1_dc_req",  64'(dc_req),  64'd1);
        chk("by_req1_dc_addr", 64'(dc_addr), 64'd0);
        v = 1'b0;
        @(negedge clk);
        chk("by_done_valid", 64'(rd_valid), 64'd1);
        chk("by_done_data",  rd_data,       64'h0000_0000_0000_00A0);
        @(negedge clk);
        chk("by_idle_valid", 64'(rd_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rd_ctrl.md
MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: V  in  1  valid micro-op in AG/ME latch.
REQ-004 SHALL have ports: MEM_RD_ME  in  1  micro-op requires memory read.
REQ-005 SHALL have ports: MEM_RD_ADDR  in  32  linear read address from AG stage.
REQ-006 SHALL have ports: MEM_SIZE  in  2  operand size: 00 byte, 01 word, 10 dword, 11 qword (MM).
REQ-007 SHALL have ports: EXC_IN  in  1  seg-limit or page-fault already flagged for this micro-op.
REQ-008 SHALL have ports: EX_READY  in  1  downstream accepts RD_DATA this cycle.
REQ-009 SHALL have ports: DC_REQ  out  1  data-cache read request.
REQ-010 SHALL have ports: DC_ADDR  out  32  16-byte-aligned line address, bits [3:0]=0.
REQ-011 SHALL have ports: DC_ACK  in  1  cache returns line this cycle.
REQ-012 SHALL have ports: DC_DATA  in  128  line data, byte k at bits [8k+7:8k].
REQ-013 SHALL have ports: RD_DATA  out  64  read result, zero-extended above operand size.
REQ-014 SHALL have ports: RD_VALID  out  1  RD_DATA valid.
REQ-015 SHALL have ports: ME_STALL  out  1  upstream hold; high whenever state != IDLE.
REQ-016 SHALL have ports: MISALIGN_EXC  out  1  line-crossing read refused (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, REQ1, REQ2, DONE.
REQ-018 IDLE SHALL accept when V & MEM_RD_ME & !EXC_IN; it latches addr and size, then goes to REQ1. Otherwise it stays in IDLE.
REQ-019 Byte count N SHALL be 1/2/4/8 per MEM_SIZE. Offset = addr[3:0]. Cross = (offset + N > 16), computed in 5 bits.
REQ-020 REQ1 SHALL drive DC_REQ=1 and DC_ADDR={addr[31:4],4'h0}, holding them stable until DC_ACK. On ACK it captures DC_DATA into line buffer 0, then goes to REQ2 if cross, else to DONE.
REQ-021 REQ2 SHALL drive DC_ADDR = line0 + 16, mod 2^32 (0xFFFFFFF0 wraps to 0x00000000). On ACK it captures line buffer 1, then goes to DONE.
REQ-022 RD_DATA SHALL contain bytes i=0..N-1, taken from byte (offset+i) of the concatenation {line1,line0}. This is little-endian; bytes >= N are 0.
REQ-023 DONE SHALL assert RD_VALID and hold RD_DATA stable until EX_READY=1, then go to IDLE. No new request is accepted on that same edge.
REQ-024 DC_REQ SHALL be 0 in IDLE and DONE. DC_ACK outside REQ1/REQ2 SHALL be ignored.
REQ-025 DC_ACK in the same cycle REQ1/REQ2 is entered SHALL be honoured (minimum 1-cycle access).
REQ-026 Latency: aligned read SHALL take accept to RD_VALID in 2 cycles with immediate ACK; a split read takes 3.
REQ-027 V, EXC_IN and MEM_RD_ADDR changes after accept SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-028 RST=0 SHALL immediately force state IDLE, with DC_REQ=0, RD_VALID=0, ME_STALL=0, MISALIGN_EXC=0, RD_DATA=0, DC_ADDR=0, and line buffers=0, independent of CLK.
REQ-029 Reset mid-transaction SHALL abandon it with no output on deassertion. The first accept is possible on the first rising edge after RST=1.

Configuration
REQ-030 Macro MEM_RD_SPLIT_EN SHALL select split handling.
- Defined: cross reads are split per REQ-020/021, and MISALIGN_EXC is tied 0.
- Undefined: a cross read performs REQ1 only, then DONE with RD_DATA=0 and MISALIGN_EXC=1 alongside RD_VALID; REQ2 is unreachable.

Verification
REQ-031 Aligned dword read: addr 0x00001004, size 10, line bytes 0..15 = 0x00..0x0F, ACK on 1st cycle -> DC_ADDR 0x00001000, RD_DATA 0x0000000007060504 two cycles after accept.
REQ-032 Split qword, macro defined: addr 0x0000200C, line0 bytes = 0xA0+k, line1 bytes = 0xB0+k -> DC_ADDR 0x2000 then 0x2010, RD_DATA 0xB3B2B1B0AFAEADAC. Same stimulus with macro undefined -> one request, MISALIGN_EXC=1, RD_DATA 0.
REQ-033 Wrap: addr 0xFFFFFFFF, size 01, macro defined -> second DC_ADDR 0x00000000, RD_DATA = {line1 byte0, line0 byte15}.
REQ-034 Backpressure and suppression: EX_READY low 3 cycles in DONE -> RD_VALID/RD_DATA held 3 cycles, ME_STALL high throughout. V=1, MEM_RD_ME=1, EXC_IN=1 -> no DC_REQ, stays IDLE.
REQ-035 Async reset: RST low while in REQ2 waiting for ACK -> DC_REQ drops the same cycle without a clock, and no RD_VALID follows. A new aligned byte read at 0x00000000 after release completes normally.
